// File: rtl/pomodoro_pkg.sv
// -----------------------------------------------------------------------------
// pomodoro_pkg
// Shared definitions for the pomodoro timer button front end.
//   N_BTN                  : default number of push-button channels
//   DEBOUNCE_CYCLES_DEF    : default stable cycles before a level change is
//                            accepted (20 ms at 125 MHz)
//   LONG_PRESS_CYCLES_DEF  : default held cycles, counted from press
//                            acceptance, before the long-press event (1 s)
//   btn_state_e            : per-channel debounce/hold FSM state
//   cnt_width()            : counter width for a given terminal count
// -----------------------------------------------------------------------------
package pomodoro_pkg;

   localparam int N_BTN                 = 4;
   localparam int DEBOUNCE_CYCLES_DEF   = 2_500_000;
   localparam int LONG_PRESS_CYCLES_DEF = 125_000_000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRESS_WAIT,
      ST_PRESSED,
      ST_LONG_HELD,
      ST_RELEASE_WAIT
   } btn_state_e;

   // Counters only ever need to hold limit-1, so $clog2(limit) bits suffice;
   // a limit of 1 would give a zero-width vector, hence the floor of 1.
   function automatic int cnt_width(input int limit);
      return (limit > 1) ? $clog2(limit) : 1;
   endfunction

endpackage : pomodoro_pkg

// File: rtl/pomo_btn_conditioner_if.sv
// -----------------------------------------------------------------------------
// pomo_btn_conditioner_if
// Bundle between the raw push buttons and the conditioned event outputs.
//   btn_raw       : raw asynchronous button levels, active-high
//   btn_level     : debounced level per channel
//   press_pulse   : 1-cycle pulse per channel on an accepted press
//   release_pulse : 1-cycle pulse per channel on an accepted release
//   long_pulse    : 1-cycle pulse per channel when a press has been held long
//   sel           : one-hot, sticky code of the last accepted press
//   sel_vld       : 1-cycle pulse when sel is updated
// Modports: master = button source / event consumer, slave = conditioner.
// -----------------------------------------------------------------------------
interface pomo_btn_conditioner_if #(
   parameter int N_BTN = pomodoro_pkg::N_BTN
);

   logic [N_BTN-1:0] btn_raw;
   logic [N_BTN-1:0] btn_level;
   logic [N_BTN-1:0] press_pulse;
   logic [N_BTN-1:0] release_pulse;
   logic [N_BTN-1:0] long_pulse;
   logic [N_BTN-1:0] sel;
   logic             sel_vld;

   modport master (
      output btn_raw,
      input  btn_level, press_pulse, release_pulse, long_pulse, sel, sel_vld
   );

   modport slave (
      input  btn_raw,
      output btn_level, press_pulse, release_pulse, long_pulse, sel, sel_vld
   );

endinterface : pomo_btn_conditioner_if

// File: rtl/btn_debounce_ch.sv
// -----------------------------------------------------------------------------
// btn_debounce_ch
// One push-button channel: 2-flop synchronizer, debounce/hold FSM, debounce
// counter and hold counter. All event outputs are registered and rise on the
// clock edge that commits the corresponding FSM transition.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   btn_raw_i    : raw asynchronous button level
//   level_o      : debounced level
//   press_o      : registered 1-cycle press pulse
//   release_o    : registered 1-cycle release pulse
//   long_o       : registered 1-cycle long-press pulse
//   press_evt_o  : combinational press decision (lets the parent register a
//                  value in the same cycle as press_o)
// -----------------------------------------------------------------------------
module btn_debounce_ch
   import pomodoro_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEF,
   parameter int LONG_PRESS_CYCLES = LONG_PRESS_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic long_o,
   output logic press_evt_o
);

   localparam int DB_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam int HOLD_W = cnt_width(LONG_PRESS_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

   // Synchronizer
   logic sync1_q, sync1_d;
   logic sync2_q, sync2_d;

   // FSM, counters and registered outputs
   btn_state_e        state_q, state_d;
   logic [DB_W-1:0]   db_cnt_q, db_cnt_d;
   logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
   logic              long_done_q, long_done_d;
   logic              level_q, level_d;
   logic              press_q, press_d;
   logic              release_q, release_d;
   logic              long_q, long_d;

   logic sync;
   assign sync = sync2_q;

   always_comb begin
      // NOTE: every signal written here gets a default first; a path that
      // leaves one unassigned would infer a latch.
      sync1_d     = btn_raw_i;
      sync2_d     = sync1_q;
      state_d     = state_q;
      db_cnt_d    = db_cnt_q;
      hold_cnt_d  = hold_cnt_q;
      long_done_d = long_done_q;
      level_d     = level_q;
      press_d     = 1'b0;
      release_d   = 1'b0;
      long_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (sync) begin
               state_d  = ST_PRESS_WAIT;
               db_cnt_d = '0;
            end
         end

         ST_PRESS_WAIT: begin
            if (!sync) begin
               state_d = ST_IDLE;            // glitch rejected silently
            end else if (db_cnt_q == DB_LAST) begin
               state_d     = ST_PRESSED;
               press_d     = 1'b1;
               level_d     = 1'b1;
               hold_cnt_d  = '0;
               long_done_d = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         ST_PRESSED: begin
            // Hold time accrues in every PRESSED cycle and saturates.
            if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
            // A low sample takes precedence: the long event is deferred until
            // the button is seen held again, and dropped if it is released.
            if (!sync) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end else if (hold_cnt_q == HOLD_LAST) begin
               state_d     = ST_LONG_HELD;
               long_d      = 1'b1;
               long_done_d = 1'b1;
            end
         end

         ST_LONG_HELD: begin
            if (!sync) begin
               state_d  = ST_RELEASE_WAIT;
               db_cnt_d = '0;
            end
         end

         ST_RELEASE_WAIT: begin
            if (sync) begin
               // Bounce during the hold: resume where we were, hold_cnt kept.
               state_d = long_done_q ? ST_LONG_HELD : ST_PRESSED;
            end else if (db_cnt_q == DB_LAST) begin
               state_d   = ST_IDLE;
               release_d = 1'b1;
               level_d   = 1'b0;
            end else begin
               db_cnt_d = db_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         state_q     <= ST_IDLE;
         db_cnt_q    <= '0;
         hold_cnt_q  <= '0;
         long_done_q <= 1'b0;
         level_q     <= 1'b0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples the values
         // from before this edge, independent of statement order.
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         state_q     <= state_d;
         db_cnt_q    <= db_cnt_d;
         hold_cnt_q  <= hold_cnt_d;
         long_done_q <= long_done_d;
         level_q     <= level_d;
         press_q     <= press_d;
         release_q   <= release_d;
         long_q      <= long_d;
      end
   end

   assign level_o     = level_q;
   assign press_o     = press_q;
   assign release_o   = release_q;
   assign long_o      = long_q;
   assign press_evt_o = press_d;

endmodule : btn_debounce_ch

// File: rtl/pomo_btn_conditioner.sv
// -----------------------------------------------------------------------------
// pomo_btn_conditioner
// Conditions N_BTN raw push buttons into debounced levels and press / release
// / long-press pulses, and keeps a sticky one-hot mode select of the last
// accepted press.
// Ports:
//   clk  : system clock (125 MHz)
//   rst  : asynchronous active-high reset
//   bus  : pomo_btn_conditioner_if.slave (btn_raw in; btn_level, press_pulse,
//          release_pulse, long_pulse, sel, sel_vld out)
// -----------------------------------------------------------------------------
module pomo_btn_conditioner #(
   parameter int N_BTN             = pomodoro_pkg::N_BTN,
   parameter int DEBOUNCE_CYCLES   = pomodoro_pkg::DEBOUNCE_CYCLES_DEF,
   parameter int LONG_PRESS_CYCLES = pomodoro_pkg::LONG_PRESS_CYCLES_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   pomo_btn_conditioner_if.slave    bus
);

   logic [N_BTN-1:0] level;
   logic [N_BTN-1:0] press;
   logic [N_BTN-1:0] release_evt;
   logic [N_BTN-1:0] long_evt;
   logic [N_BTN-1:0] press_evt;

   logic [N_BTN-1:0] sel_q, sel_d;
   logic             sel_vld_q, sel_vld_d;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      btn_debounce_ch #(
         .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
         .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .btn_raw_i   (bus.btn_raw[g]),
         .level_o     (level[g]),
         .press_o     (press[g]),
         .release_o   (release_evt[g]),
         .long_o      (long_evt[g]),
         .press_evt_o (press_evt[g])
      );
   end

   // sel is loaded from the channels' press decisions, so it changes on the
   // same edge as press_pulse. Ascending scan: the highest pressed index is
   // written last and wins.
   always_comb begin
      sel_d     = sel_q;
      sel_vld_d = 1'b0;
      for (int i = 0; i < N_BTN; i++) begin
         if (press_evt[i]) begin
            sel_d     = '0;
            sel_d[i]  = 1'b1;
            sel_vld_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel_q     <= '0;
         sel_vld_q <= 1'b0;
      end else begin
         sel_q     <= sel_d;
         sel_vld_q <= sel_vld_d;
      end
   end

   assign bus.btn_level     = level;
   assign bus.press_pulse   = press;
   assign bus.release_pulse = release_evt;
   assign bus.long_pulse    = long_evt;
   assign bus.sel           = sel_q;
   assign bus.sel_vld       = sel_vld_q;

endmodule : pomo_btn_conditioner

// File: tb/tb_pomo_btn_conditioner.sv
// -----------------------------------------------------------------------------
// tb_pomo_btn_conditioner
// Directed scenarios plus a randomized phase, compared every cycle against a
// run-length model of the button conditioner.
// -----------------------------------------------------------------------------
module tb_pomo_btn_conditioner;

   localparam int N  = 4;
   localparam int DB = 4;
   localparam int LP = 20;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;

   int n_chk = 0;
   int n_err = 0;

   pomo_btn_conditioner_if #(.N_BTN(N)) bus ();

   pomo_btn_conditioner #(
      .N_BTN             (N),
      .DEBOUNCE_CYCLES   (DB),
      .LONG_PRESS_CYCLES (LP)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", tag, cyc, got, exp);
      end
   endtask

   // ---------------------------------------------------------------------
   // Reference model. A channel flips its debounced level once the
   // synchronized input has disagreed with it for DB+1 consecutive samples.
   // Hold time accrues while pressed, no long event yet, and the previous
   // sample agreed with the level; the long event fires on a high sample
   // once LP-1 has been accumulated.
   // ---------------------------------------------------------------------
   logic [N-1:0] m_s1, m_s2;
   logic [N-1:0] m_lvl, m_ld;
   logic [N-1:0] m_press, m_rel, m_long, m_sel;
   logic         m_vld;
   int           m_run [N];
   int           m_hold [N];

   task automatic model_step();
      logic [N-1:0] s;
      bit           holding;
      if (rst) begin
         m_s1 = '0; m_s2 = '0; m_lvl = '0; m_ld = '0;
         m_press = '0; m_rel = '0; m_long = '0; m_sel = '0; m_vld = 1'b0;
         for (int i = 0; i < N; i++) begin
            m_run[i]  = 0;
            m_hold[i] = 0;
         end
         return;
      end
      s       = m_s2;
      m_s2    = m_s1;
      m_s1    = bus.btn_raw;
      m_press = '0;
      m_rel   = '0;
      m_long  = '0;
      for (int i = 0; i < N; i++) begin
         holding = m_lvl[i] && (m_run[i] == 0) && !m_ld[i];
         if (holding) begin
            if (s[i] && m_hold[i] == LP - 1) begin
               m_long[i] = 1'b1;
               m_ld[i]   = 1'b1;
            end else if (m_hold[i] < LP - 1) begin
               m_hold[i]++;
            end
         end
         if (s[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DB + 1) begin
               m_run[i] = 0;
               m_lvl[i] = s[i];
               if (s[i]) begin
                  m_press[i] = 1'b1;
                  m_hold[i]  = 0;
                  m_ld[i]    = 1'b0;
               end else begin
                  m_rel[i] = 1'b1;
               end
            end
         end else begin
            m_run[i] = 0;
         end
      end
      m_vld = (m_press != '0);
      if (m_vld) begin
         for (int i = N - 1; i >= 0; i--) begin
            if (m_press[i]) begin
               m_sel = '0;
               m_sel[i] = 1'b1;
               break;
            end
         end
      end
   endtask

   // Observations of DUT events for the directed scenarios.
   int           press_cnt [N], release_cnt [N], long_cnt [N];
   int           press_cyc [N], release_cyc [N], long_cyc [N];
   logic [N-1:0] level_seen, last_press_vec, last_sel;
   logic         last_vld;

   task automatic clear_obs();
      for (int i = 0; i < N; i++) begin
         press_cnt[i] = 0; release_cnt[i] = 0; long_cnt[i] = 0;
         press_cyc[i] = -1; release_cyc[i] = -1; long_cyc[i] = -1;
      end
      level_seen = '0; last_press_vec = '0; last_sel = '0; last_vld = 1'b0;
   endtask

   always @(posedge clk) begin
      cyc++;
      #1;
      model_step();
      check("btn_level",     bus.btn_level,     m_lvl);
      check("press_pulse",   bus.press_pulse,   m_press);
      check("release_pulse", bus.release_pulse, m_rel);
      check("long_pulse",    bus.long_pulse,    m_long);
      check("sel",           bus.sel,           m_sel);
      check("sel_vld",       bus.sel_vld,       m_vld);
      level_seen |= bus.btn_level;
      if (bus.press_pulse != '0) begin
         last_press_vec = bus.press_pulse;
         last_sel       = bus.sel;
         last_vld       = bus.sel_vld;
      end
      for (int i = 0; i < N; i++) begin
         if (bus.press_pulse[i])   begin press_cnt[i]++;   press_cyc[i]   = cyc; end
         if (bus.release_pulse[i]) begin release_cnt[i]++; release_cyc[i] = cyc; end
         if (bus.long_pulse[i])    begin long_cnt[i]++;    long_cyc[i]    = cyc; end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   int t0, t1;
   int dur [N];

   initial begin
      bus.btn_raw = '0;
      clear_obs();

      // Reset state
      idle(3);
      check("rst_level", bus.btn_level, '0);
      check("rst_press", bus.press_pulse, '0);
      check("rst_sel",   bus.sel, '0);
      check("rst_vld",   bus.sel_vld, 1'b0);
      rst = 1'b0;
      idle(5);

      // Short glitch on channel 1 is rejected
      clear_obs();
      bus.btn_raw[1] = 1'b1; idle(3);
      bus.btn_raw[1] = 1'b0; idle(15);
      check("glitch_press_cnt", press_cnt[1], 0);
      check("glitch_level",     level_seen, '0);

      // Clean press/release on channel 2
      clear_obs();
      t0 = cyc; bus.btn_raw[2] = 1'b1; idle(10);
      t1 = cyc; bus.btn_raw[2] = 1'b0; idle(15);
      check("c2_press_cnt",   press_cnt[2], 1);
      check("c2_press_lat",   press_cyc[2] - t0, DB + 3);
      check("c2_press_vec",   last_press_vec, 4'b0100);
      check("c2_sel",         last_sel, 4'b0100);
      check("c2_sel_vld",     last_vld, 1'b1);
      check("c2_release_cnt", release_cnt[2], 1);
      check("c2_release_lat", release_cyc[2] - t1, DB + 3);
      check("c2_long_cnt",    long_cnt[2], 0);

      // Long press on channel 0
      clear_obs();
      t0 = cyc; bus.btn_raw[0] = 1'b1; idle(40);
      t1 = cyc; bus.btn_raw[0] = 1'b0; idle(15);
      check("c0_press_lat",   press_cyc[0] - t0, DB + 3);
      check("c0_long_cnt",    long_cnt[0], 1);
      check("c0_long_lat",    long_cyc[0] - press_cyc[0], LP);
      check("c0_release_cnt", release_cnt[0], 1);
      check("c0_release_lat", release_cyc[0] - t1, DB + 3);

      // Simultaneous presses on channels 3 and 1
      clear_obs();
      bus.btn_raw[3] = 1'b1; bus.btn_raw[1] = 1'b1; idle(12);
      bus.btn_raw[3] = 1'b0; bus.btn_raw[1] = 1'b0; idle(15);
      check("sim_press_vec", last_press_vec, 4'b1010);
      check("sim_sel",       last_sel, 4'b1000);
      check("sim_same_cyc",  press_cyc[3] - press_cyc[1], 0);
      check("sim_cnt1",      press_cnt[1], 1);
      check("sim_cnt3",      press_cnt[3], 1);

      // Held channel 2 with short low bounces
      clear_obs();
      bus.btn_raw[2] = 1'b1; idle(10);
      bus.btn_raw[2] = 1'b0; idle(2);
      bus.btn_raw[2] = 1'b1; idle(8);
      bus.btn_raw[2] = 1'b0; idle(2);
      bus.btn_raw[2] = 1'b1; idle(30);
      bus.btn_raw[2] = 1'b0; idle(15);
      check("bnc_press_cnt",   press_cnt[2], 1);
      check("bnc_release_cnt", release_cnt[2], 1);
      check("bnc_long_cnt",    long_cnt[2], 1);

      // Reset while channel 1 is held in PRESSED
      bus.btn_raw[1] = 1'b1; idle(12);
      clear_obs();
      rst = 1'b1; idle(2);
      check("mid_rst_level", bus.btn_level, '0);
      check("mid_rst_press", bus.press_pulse, '0);
      check("mid_rst_sel",   bus.sel, '0);
      check("mid_rst_vld",   bus.sel_vld, 1'b0);
      rst = 1'b0; t0 = cyc; idle(12);
      check("mid_rst_release_cnt", release_cnt[1], 0);
      check("mid_rst_press_cnt",   press_cnt[1], 1);
      check("mid_rst_press_lat",   press_cyc[1] - t0, DB + 3);
      bus.btn_raw[1] = 1'b0; idle(15);

      // Randomized phase: per-channel levels with mixed bounce/hold lengths
      for (int i = 0; i < N; i++) dur[i] = $urandom_range(1, 30);
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (dur[i] == 0) begin
               bus.btn_raw[i] = ~bus.btn_raw[i];
               dur[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4)
                                                    : $urandom_range(3, 35);
            end else begin
               dur[i]--;
            end
         end
         if ($urandom_range(0, 299) == 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
         end
      end
      bus.btn_raw = '0;
      idle(20);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule : tb_pomo_btn_conditioner
